// File: rtl/ram_address_sequencer.sv
// rtl/ram_address_sequencer.sv - RAM address counter with synchronised load/step strobes
// Wraps or saturates (sticky overflow) at the address boundaries.
module ram_address_sequencer #(
   parameter int ADDR_WIDTH  = 24,
   parameter int ADDR_MAX    = 2**ADDR_WIDTH-1,
   parameter int STEP        = 1,
   parameter int SYNC_STAGES = 2,
   parameter int WRAP_EN     = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] addr_in,
   input  logic                  ld_addr,
   input  logic                  inc_addr,
   input  logic                  dir,
   output logic [ADDR_WIDTH-1:0] addr_out,
   output logic                  wrap,
   output logic                  overflow,
   output logic                  debug
);

   localparam logic [ADDR_WIDTH:0] LP_MAX  = (ADDR_WIDTH+1)'(ADDR_MAX);
   localparam logic [ADDR_WIDTH:0] LP_STEP = (ADDR_WIDTH+1)'(STEP);
   localparam logic [ADDR_WIDTH:0] LP_ONE  = (ADDR_WIDTH+1)'(1);

   logic [SYNC_STAGES-1:0] r_ld_sync;
   logic [SYNC_STAGES-1:0] r_inc_sync;
   logic                   r_ld_prev;
   logic                   r_inc_prev;
   logic [ADDR_WIDTH-1:0]  r_hold;
   logic [ADDR_WIDTH-1:0]  r_addr;
   logic                   r_wrap;
   logic                   r_ovf;

   logic                   w_ld_s;
   logic                   w_inc_s;
   logic                   w_ld_evt;
   logic                   w_inc_evt;
   logic [ADDR_WIDTH:0]    w_addr_ext;
   logic [ADDR_WIDTH:0]    w_sum;
   logic                   w_up_over;
   logic                   w_dn_under;
   logic                   w_step_wraps;
   logic [ADDR_WIDTH-1:0]  w_step_val;
   logic [ADDR_WIDTH-1:0]  w_load_val;

   assign w_ld_s     = r_ld_sync[SYNC_STAGES-1];
   assign w_inc_s    = r_inc_sync[SYNC_STAGES-1];
   // Rising edges: the address changes only once the bus access is over.
   assign w_ld_evt   = w_ld_s & ~r_ld_prev;
   assign w_inc_evt  = w_inc_s & ~r_inc_prev;
   assign w_addr_ext = {1'b0, r_addr};
   assign w_sum      = w_addr_ext + LP_STEP;
   assign w_load_val = ({1'b0, r_hold} > LP_MAX) ? ADDR_WIDTH'(LP_MAX) : r_hold;

   always_comb begin
      w_up_over    = (w_sum > LP_MAX);
      w_dn_under   = (w_addr_ext < LP_STEP);
      w_step_wraps = dir ? w_dn_under : w_up_over;
      w_step_val   = r_addr;
      if (dir) begin
         w_step_val = w_dn_under ? ADDR_WIDTH'(LP_MAX + LP_ONE + w_addr_ext - LP_STEP)
                                 : ADDR_WIDTH'(w_addr_ext - LP_STEP);
      end else begin
         w_step_val = w_up_over ? ADDR_WIDTH'(w_sum - LP_MAX - LP_ONE)
                                : ADDR_WIDTH'(w_sum);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ld_sync  <= '1;
         r_inc_sync <= '1;
         r_ld_prev  <= 1'b1;
         r_inc_prev <= 1'b1;
         r_hold     <= '0;
         r_addr     <= '0;
         r_wrap     <= 1'b0;
         r_ovf      <= 1'b0;
      end else begin
         r_ld_sync  <= {r_ld_sync[SYNC_STAGES-2:0], ld_addr};
         r_inc_sync <= {r_inc_sync[SYNC_STAGES-2:0], inc_addr};
         r_ld_prev  <= w_ld_s;
         r_inc_prev <= w_inc_s;
         r_wrap     <= 1'b0;
         if (!w_ld_s) begin
            r_hold <= addr_in;
         end
         // Load has priority; a coincident step is dropped.
         if (w_ld_evt) begin
            r_addr <= w_load_val;
            r_ovf  <= 1'b0;
         end else if (w_inc_evt) begin
            if (!w_step_wraps) begin
               r_addr <= w_step_val;
            end else if (WRAP_EN != 0) begin
               r_addr <= w_step_val;
               r_wrap <= 1'b1;
            end else begin
               r_ovf <= 1'b1;
            end
         end
      end
   end

   assign addr_out = r_addr;
   assign wrap     = r_wrap;
   assign overflow = r_ovf;
   assign debug    = w_inc_s;

endmodule

// File: tb/tb_ram_address_sequencer.sv
// tb/tb_ram_address_sequencer.sv - randomized self-checking bench for ram_address_sequencer
// Two instances: default wrapping config and an 11-bit saturating config (max 0x3FF, step 4).
module tb_ram_address_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [23:0] a_addr_in;
   logic        a_ld, a_inc, a_dir;
   logic [23:0] a_addr;
   logic        a_wrap, a_ovf, a_dbg;
   logic [10:0] s_addr_in;
   logic        s_ld, s_inc, s_dir;
   logic [10:0] s_addr;
   logic        s_wrap, s_ovf, s_dbg;

   int          n_checks = 0;
   int          n_fail   = 0;
   longint      m_addr[2];
   bit          m_ovf[2];

   always #5 clk = ~clk;

   ram_address_sequencer u_dut (
      .clk(clk), .reset(rst_n), .addr_in(a_addr_in), .ld_addr(a_ld),
      .inc_addr(a_inc), .dir(a_dir), .addr_out(a_addr), .wrap(a_wrap),
      .overflow(a_ovf), .debug(a_dbg)
   );

   ram_address_sequencer #(
      .ADDR_WIDTH(11), .ADDR_MAX(32'h3FF), .STEP(4), .SYNC_STAGES(2), .WRAP_EN(0)
   ) u_sat (
      .clk(clk), .reset(rst_n), .addr_in(s_addr_in), .ld_addr(s_ld),
      .inc_addr(s_inc), .dir(s_dir), .addr_out(s_addr), .wrap(s_wrap),
      .overflow(s_ovf), .debug(s_dbg)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] obs_addr(input int sel);
      return (sel == 0) ? {8'h0, a_addr} : {21'h0, s_addr};
   endfunction

   function automatic logic obs_wrap(input int sel);
      return (sel == 0) ? a_wrap : s_wrap;
   endfunction

   function automatic logic obs_ovf(input int sel);
      return (sel == 0) ? a_ovf : s_ovf;
   endfunction

   function automatic logic obs_dbg(input int sel);
      return (sel == 0) ? a_dbg : s_dbg;
   endfunction

   task automatic set_ld(input int sel, input logic v);
      if (sel == 0) a_ld = v; else s_ld = v;
   endtask

   task automatic set_inc(input int sel, input logic v);
      if (sel == 0) a_inc = v; else s_inc = v;
   endtask

   task automatic check_state(input int sel, input string tag, input logic exp_wrap);
      check_eq({tag, "_addr"}, obs_addr(sel), 32'(m_addr[sel]));
      check_eq({tag, "_ovf"}, 32'(obs_ovf(sel)), 32'(m_ovf[sel]));
      check_eq({tag, "_wrap"}, 32'(obs_wrap(sel)), 32'(exp_wrap));
   endtask

   task automatic do_load(input int sel, input logic [23:0] val, input int low_clks);
      longint v;
      longint max;
      max = (sel == 0) ? 64'hFFFFFF : 64'h3FF;
      if (sel == 0) a_addr_in = val; else s_addr_in = val[10:0];
      set_ld(sel, 1'b0);
      repeat (low_clks) tick();
      check_state(sel, "ld_low", 1'b0);
      set_ld(sel, 1'b1);
      tick();
      tick();
      check_state(sel, "ld_pre", 1'b0);
      tick();
      v = (sel == 0) ? longint'(val) : longint'(val[10:0]);
      m_addr[sel] = (v > max) ? max : v;
      m_ovf[sel]  = 1'b0;
      check_state(sel, "ld_done", 1'b0);
      tick();
   endtask

   task automatic do_step(input int sel, input logic d, input int low_clks);
      longint max, step, n;
      bit     wr, exp_w;
      max   = (sel == 0) ? 64'hFFFFFF : 64'h3FF;
      step  = (sel == 0) ? 1 : 4;
      wr    = (sel == 0);
      exp_w = 1'b0;
      if (sel == 0) a_dir = d; else s_dir = d;
      set_inc(sel, 1'b0);
      repeat (low_clks) tick();
      check_state(sel, "st_low", 1'b0);
      check_eq("st_dbg_low", 32'(obs_dbg(sel)), 32'd0);
      set_inc(sel, 1'b1);
      tick();
      tick();
      check_state(sel, "st_pre", 1'b0);
      tick();
      n = m_addr[sel];
      if (!d) begin
         if (n + step > max) begin
            if (wr) begin n = n + step - max - 1; exp_w = 1'b1; end
            else m_ovf[sel] = 1'b1;
         end else n = n + step;
      end else begin
         if (n < step) begin
            if (wr) begin n = max + 1 + n - step; exp_w = 1'b1; end
            else m_ovf[sel] = 1'b1;
         end else n = n - step;
      end
      m_addr[sel] = n;
      check_state(sel, "st_done", exp_w);
      check_eq("st_dbg_high", 32'(obs_dbg(sel)), 32'd1);
      tick();
      check_state(sel, "st_after", 1'b0);
   endtask

   initial begin
      rst_n = 1'b0;
      a_addr_in = '0; a_ld = 1'b1; a_inc = 1'b1; a_dir = 1'b0;
      s_addr_in = '0; s_ld = 1'b1; s_inc = 1'b1; s_dir = 1'b0;
      m_addr[0] = 0; m_addr[1] = 0; m_ovf[0] = 0; m_ovf[1] = 0;
      repeat (3) tick();
      for (int s = 0; s < 2; s++) begin
         check_state(s, "rst", 1'b0);
         check_eq("rst_dbg", 32'(obs_dbg(s)), 32'd1);
      end
      rst_n = 1'b1;
      tick();
      check_state(0, "rel", 1'b0);
      check_eq("rel_dbg", 32'(a_dbg), 32'd1);

      do_load(0, 24'h123456, 5);
      repeat (3) do_step(0, 1'b0, 3);
      check_eq("dflt_seq", {8'h0, a_addr}, 32'h123459);

      do_load(0, 24'hFFFFFF, 3);
      do_step(0, 1'b0, 3);
      check_eq("wrap_up", {8'h0, a_addr}, 32'h000000);
      do_step(0, 1'b1, 3);
      check_eq("wrap_dn", {8'h0, a_addr}, 32'hFFFFFF);

      do_load(1, 24'h3FE, 3);
      do_step(1, 1'b0, 3);
      check_eq("sat_hold", {21'h0, s_addr}, 32'h3FE);
      check_eq("sat_ovf", 32'(s_ovf), 32'd1);
      do_load(1, 24'h010, 3);
      check_eq("sat_clr", 32'(s_ovf), 32'd0);
      do_load(1, 24'h7FF, 3);
      check_eq("clamp", {21'h0, s_addr}, 32'h3FF);
      do_load(1, 24'h002, 3);
      do_step(1, 1'b1, 4);
      check_eq("sat_dn", {21'h0, s_addr}, 32'h002);

      do_load(0, 24'h000050, 3);
      a_addr_in = 24'h000100;
      a_ld = 1'b0; a_inc = 1'b0; a_dir = 1'b0;
      repeat (4) tick();
      a_ld = 1'b1; a_inc = 1'b1;
      repeat (3) tick();
      m_addr[0] = 64'h100;
      check_state(0, "simul", 1'b0);
      tick();
      check_state(0, "simul_after", 1'b0);

      do_step(0, 1'b0, 100);

      for (int i = 0; i < 40; i++) begin
         int sel;
         int low;
         logic [23:0] v;
         sel = int'($urandom_range(0, 1));
         low = int'($urandom_range(3, 8));
         if ($urandom_range(0, 2) == 0) begin
            if (sel == 0) v = ($urandom_range(0, 1) == 1) ? 24'($urandom) : 24'hFFFFFF - 24'($urandom_range(0, 2));
            else v = ($urandom_range(0, 1) == 1) ? 24'($urandom_range(0, 2047)) : 24'($urandom_range(0, 6));
            do_load(sel, v, low);
         end else begin
            do_step(sel, 1'($urandom_range(0, 1)), low);
         end
      end

      a_addr_in = 24'hABCDEF; a_ld = 1'b0; a_inc = 1'b0; a_dir = 1'b0;
      repeat (4) tick();
      #2 rst_n = 1'b0;
      #1;
      m_addr[0] = 0; m_addr[1] = 0; m_ovf[0] = 0; m_ovf[1] = 0;
      check_state(0, "mid_rst", 1'b0);
      check_state(1, "mid_rst_s", 1'b0);
      tick();
      rst_n = 1'b1;
      tick();
      check_state(0, "rel2", 1'b0);
      do_load(0, 24'hABCDEF, 3);
      check_eq("rst_load", {8'h0, a_addr}, 32'hABCDEF);
      do_step(0, 1'b0, 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
